sram_responder: RTL and testbench

Synthesizable responder for the off-chip SRAM pin interface: the memory-device end of the 64-bit `SRAM_DQ` / 17-bit `SRAM_ADDR` / `SRAM_WE_N` bus driven by the MEM-stage SRAM controller. It holds a 64-bit-wide word array and returns read data after a programmable access latency. It commits writes on the rising edge of `SRAM_WE_N`. It serves as the SRAM stand-in for full-pipeline simulation and FPGA builds without the external chip.

---
 rtl/sram_resp_pkg.sv | 21 ++
 rtl/sram_resp_array.sv | 30 +++
 rtl/sram_responder.sv | 174 +++++++++++++++++
 tb/tb_sram_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and widths for the SRAM pin-bus responder.
package sram_resp_pkg;

  localparam int SRAM_DQ_W    = 64;
  localparam int SRAM_ADDR_W  = 17;
  localparam int READ_LAT_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_VALID  = 2'd2
  } rd_state_e;

  // Bits needed to hold a latency countdown that starts at lat-1.
  function automatic int cnt_width(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

  localparam int CNT_W = cnt_width(READ_LAT_DEF);

endpackage

// File: rtl/sram_resp_array.sv
// 2^DEPTH_W x 64 word store: one synchronous write port, one registered read port.
module sram_resp_array
  import sram_resp_pkg::*;
#(
  parameter int DEPTH_W = SRAM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [DEPTH_W-1:0]   waddr_i,
  input  logic [SRAM_DQ_W-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [DEPTH_W-1:0]   raddr_i,
  output logic [SRAM_DQ_W-1:0] rdata_o
);

  logic [SRAM_DQ_W-1:0] mem_q [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Device end of the SRAM pin bus: latency-programmable reads, writes committed on WE_N rise.
// Define SRAM_RESP_ERRCHK_EN to compile in the write-timing checker that drives timing_err.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int READ_LAT = READ_LAT_DEF,
  parameter int WR_MIN   = 2,
  parameter int DEPTH_W  = SRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  input  logic                   SRAM_WE_N,
  output logic                   rd_valid,
  output logic [15:0]            read_count,
  output logic [15:0]            write_count,
  output logic                   timing_err
);

  // Never narrower than the default-latency counter, so cnt encodings line up across builds.
  localparam int CntW = (cnt_width(READ_LAT) > CNT_W) ? cnt_width(READ_LAT) : CNT_W;
  localparam int LowW = (WR_MIN > 0) ? $clog2(WR_MIN + 1) : 1;
  localparam logic [CntW-1:0] CNT_LOAD = CntW'(READ_LAT - 1);
  localparam logic [LowW-1:0] LOW_SAT  = LowW'(WR_MIN);

  rd_state_e              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic                   restart, rd_en, rd_done;

  logic [15:0]            read_count_q, write_count_q;
  logic                   we_n_dly_q;
  logic [LowW-1:0]        low_cnt_q, low_cnt_d;
  logic [SRAM_ADDR_W-1:0] wr_addr_q;
  logic [SRAM_DQ_W-1:0]   wr_data_q;
  logic                   commit_edge, commit;

  logic                   byp_q;
  logic [SRAM_DQ_W-1:0]   byp_data_q;
  logic [SRAM_DQ_W-1:0]   ram_rdata, dq_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    restart     = 1'b0;
    rd_en       = 1'b0;
    rd_done     = 1'b0;
    if (!SRAM_WE_N) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: restart = 1'b1;
        ST_ACCESS: begin
          if (SRAM_ADDR != last_addr_q) begin
            restart = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              state_d = ST_VALID;
              rd_en   = 1'b1;
              rd_done = 1'b1;
            end
          end
        end
        ST_VALID: begin
          if (SRAM_ADDR != last_addr_q) begin
            restart = 1'b1;
          end else begin
            rd_en = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // The array read is issued on the edge entering VALID, so VALID lands READ_LAT cycles after start.
      if (restart) begin
        last_addr_d = SRAM_ADDR;
        cnt_d       = CNT_LOAD;
        if (CNT_LOAD == '0) begin
          state_d = ST_VALID;
          rd_en   = 1'b1;
          rd_done = 1'b1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
    end
  end

  always_comb begin
    low_cnt_d = '0;
    if (!SRAM_WE_N) begin
      low_cnt_d = (low_cnt_q == LOW_SAT) ? low_cnt_q : low_cnt_q + LowW'(1);
    end
  end

  assign commit_edge = SRAM_WE_N & ~we_n_dly_q;

`ifdef SRAM_RESP_ERRCHK_EN
  logic err_q, short_pulse, addr_skew;

  assign short_pulse = commit_edge && (low_cnt_q < LOW_SAT);
  assign addr_skew   = !SRAM_WE_N && !we_n_dly_q && (SRAM_ADDR != wr_addr_q);
  assign commit      = commit_edge && !short_pulse;
  assign timing_err  = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (short_pulse || addr_skew) begin
      err_q <= 1'b1;
    end
  end
`else
  assign commit     = commit_edge && (low_cnt_q != '0);
  assign timing_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_addr_q   <= '0;
      read_count_q  <= '0;
      write_count_q <= '0;
      we_n_dly_q    <= 1'b1;
      low_cnt_q     <= '0;
      byp_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      we_n_dly_q  <= SRAM_WE_N;
      low_cnt_q   <= low_cnt_d;
      if (rd_done) begin
        read_count_q <= read_count_q + 16'd1;
      end
      if (commit) begin
        write_count_q <= write_count_q + 16'd1;
      end
      // A read issued on the commit edge of the same word must see the new data.
      byp_q <= commit && rd_en &&
               (wr_addr_q[DEPTH_W-1:0] == SRAM_ADDR[DEPTH_W-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!SRAM_WE_N) begin
      wr_addr_q <= SRAM_ADDR;
      wr_data_q <= SRAM_DQ;
    end
    byp_data_q <= wr_data_q;
  end

  sram_resp_array #(
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk     (clk),
    .we_i    (commit),
    .waddr_i (wr_addr_q[DEPTH_W-1:0]),
    .wdata_i (wr_data_q),
    .re_i    (rd_en),
    .raddr_i (SRAM_ADDR[DEPTH_W-1:0]),
    .rdata_o (ram_rdata)
  );

  assign dq_out      = byp_q ? byp_data_q : ram_rdata;
  assign rd_valid    = (state_q == ST_VALID);
  assign read_count  = read_count_q;
  assign write_count = write_count_q;
  assign SRAM_DQ     = (rd_valid && SRAM_WE_N) ? dq_out : {SRAM_DQ_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder (READ_LAT=5, WR_MIN=2, DEPTH_W=10); honours SRAM_RESP_ERRCHK_EN.
module tb_sram_responder;

  localparam int LAT = 5;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  wire  [63:0] dq;
  logic [63:0] tb_dq;
  logic        tb_oe;
  logic [16:0] addr;
  logic        we_n;
  logic        rd_valid, timing_err;
  logic [15:0] read_count, write_count;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic chk_q = 1'b0;
  logic oe_obs;

`ifdef SRAM_RESP_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  assign dq = tb_oe ? tb_dq : 64'bz;

  sram_responder #(
    .READ_LAT (LAT),
    .WR_MIN   (2),
    .DEPTH_W  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .SRAM_DQ     (dq),
    .SRAM_ADDR   (addr),
    .SRAM_WE_N   (we_n),
    .rd_valid    (rd_valid),
    .read_count  (read_count),
    .write_count (write_count),
    .timing_err  (timing_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expected data cycle must show the block driving that word; checked quiet cycles must not.
  always @(negedge clk) begin
    oe_obs = rd_valid && we_n;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: cycle %0d passed without check, want dq=%h", e.tag, e.cyc, e.data);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      if (!oe_obs || dq !== e.data) begin
        n_err++;
        $display("FAIL %s cyc %0d: oe=%0b dq=%h, want oe=1 dq=%h", e.tag, cyc, oe_obs, dq, e.data);
      end
    end else if (chk_q) begin
      n_vec++;
      if (oe_obs || (!tb_oe && dq !== 64'bz)) begin
        n_err++;
        $display("FAIL quiet cyc %0d: oe=%0b dq=%h, want oe=0 and bus released", cyc, oe_obs, dq);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic drive_low(input logic [16:0] a, input logic [63:0] d);
    we_n  = 1'b0;
    addr  = a;
    tb_dq = d;
    tb_oe = 1'b1;
    chk_q = 1'b1;
    step();
  endtask

  task automatic write(input logic [16:0] a, input logic [63:0] d, input int n);
    $display("write addr=%h data=%h low_cycles=%0d", a, d, n);
    for (int i = 0; i < n; i++) drive_low(a, d);
  endtask

  // Hold WE_N high for 'hold' cycles; address moves to a1 at offset sw (sw >= hold means never).
  task automatic read_seq(input logic [16:0] a0, input logic [16:0] a1, input int sw,
                          input int hold, input logic [63:0] exp_d, input string tag);
    int t, start;
    tb_oe = 1'b0;
    we_n  = 1'b1;
    addr  = a0;
    t     = cyc;
    start = (sw < hold) ? t + sw : t;
    $display("read  addr=%h switch_to=%h at+%0d hold=%0d expect=%h from cycle %0d",
             a0, a1, sw, hold, exp_d, start + LAT);
    for (int k = start + LAT; k < t + hold; k++) exp_q.push_back('{k, exp_d, tag});
    for (int i = 0; i < hold; i++) begin
      if (i == sw) addr = a1;
      chk_q = 1'b1;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    we_n  = 1'b1;
    addr  = '0;
    tb_dq = '0;
    tb_oe = 1'b0;
    step();
    step();
    check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("reset_read_count", {48'd0, read_count}, 64'd0);
    check("reset_write_count", {48'd0, write_count}, 64'd0);
    check("reset_timing_err", {63'd0, timing_err}, 64'd0);
    check("reset_dq_released", {63'd0, (dq !== 64'bz)}, 64'd0);
    reset = 1'b0;

    write(17'h00010, 64'h1122334455667788, 3);
    read_seq(17'h00010, 17'h00010, 99, 8, 64'h1122334455667788, "read_lat5");
    check("wc_after_first_write", {48'd0, write_count}, 64'd1);
    check("rc_after_first_read", {48'd0, read_count}, 64'd1);
    check("te_clean_write", {63'd0, timing_err}, 64'd0);

    write(17'h00011, 64'hCAFEF00D12345678, 2);
    read_seq(17'h00010, 17'h00011, 2, 10, 64'hCAFEF00D12345678, "read_restart");
    check("rc_after_restart", {48'd0, read_count}, 64'd2);
    check("wc_after_second_write", {48'd0, write_count}, 64'd2);

    $display("write addr_skew 00030->00031");
    drive_low(17'h00030, 64'h0101010101010101);
    drive_low(17'h00031, 64'h7777666655554444);
    read_seq(17'h00031, 17'h00031, 99, 6, 64'h7777666655554444, "read_final_addr");
    check("te_after_addr_skew", {63'd0, timing_err}, {63'd0, ERRCHK});
    check("wc_after_skew_write", {48'd0, write_count}, 64'd3);

    write(17'h00020, 64'h000000000000BEEF, 2);
    read_seq(17'h00020, 17'h00020, 99, 6, 64'h000000000000BEEF, "read_beef");
    write(17'h00050, 64'h0000000000005555, 2);
    read_seq(17'h00050, 17'h00050, 99, 6, 64'h0000000000005555, "read_5555");
    write(17'h00020, 64'h000000000000DEAD, 1);
    read_seq(17'h00020, 17'h00020, 99, 7,
             ERRCHK ? 64'h000000000000BEEF : 64'h000000000000DEAD, "read_short_pulse");
    check("wc_after_short_pulse", {48'd0, write_count}, ERRCHK ? 64'd5 : 64'd6);
    check("te_after_short_pulse", {63'd0, timing_err}, {63'd0, ERRCHK});
    check("rc_after_short_pulse", {48'd0, read_count}, 64'd6);

    write(17'h00400, 64'h000000000000A5A5, 2);
    read_seq(17'h00000, 17'h00000, 99, 6, 64'h000000000000A5A5, "read_alias");
    check("wc_after_alias", {48'd0, write_count}, ERRCHK ? 64'd6 : 64'd7);
    check("rc_after_alias", {48'd0, read_count}, 64'd7);

    write(17'h00050, 64'h0000000000009999, 2);
    $display("reset during write phase");
    reset = 1'b1;
    chk_q = 1'b0;
    step();
    check("rst_mid_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_mid_write_count", {48'd0, write_count}, 64'd0);
    check("rst_mid_read_count", {48'd0, read_count}, 64'd0);
    check("rst_mid_timing_err", {63'd0, timing_err}, 64'd0);
    reset = 1'b0;
    read_seq(17'h00050, 17'h00050, 99, 6, 64'h0000000000005555, "read_after_rst");
    check("wc_no_commit_after_rst", {48'd0, write_count}, 64'd0);
    check("rc_after_rst_read", {48'd0, read_count}, 64'd1);

    chk_q = 1'b0;
    step();
    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
